// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the memory stage and a variable-latency data memory.
//
// Handshake: the master raises dm_req with dm_we/dm_size/dm_addr/dm_wdata
// stable and holds all of them until the slave returns a single-cycle dm_ack.
// dm_rdata is only meaningful in the dm_ack cycle. The master may withdraw
// dm_req without an ack (timeout abort). An ack arriving while dm_req is low
// carries no meaning and is ignored by the master.
interface mem_access_unit_if;
    logic        dm_req;
    logic        dm_we;
    logic [1:0]  dm_size;
    logic [63:0] dm_addr;
    logic [63:0] dm_wdata;
    logic        dm_ack;
    logic [63:0] dm_rdata;

    modport master (
        output dm_req, dm_we, dm_size, dm_addr, dm_wdata,
        input  dm_ack, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_size, dm_addr, dm_wdata,
        output dm_ack, dm_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory stage of the pipeline: issues one data-memory access at a time,
// stalls the upstream stages while it is outstanding, feeds a bubble into
// MEM/WB (which has no enable) during the stall, and delivers the result in
// a single DONE cycle. Misaligned accesses and timeouts raise mem_fault and
// suppress the register write.
module mem_access_unit #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead_mem,
    input  logic        MemWrite_mem,
    input  logic        MemtoReg_mem,
    input  logic        RegWrite_mem,
    input  logic        BrTaken_mem,
    input  logic [1:0]  xfer_size_mem,
    input  logic [4:0]  Rd_mem,
    input  logic [63:0] alu_result_mem,
    input  logic [63:0] wr_data_mem,
    mem_access_unit_if.master dm,
    output logic        mem_stall,
    output logic        mem_fault,
    output logic        MemtoReg_out,
    output logic        RegWrite_out,
    output logic        BrTaken_out,
    output logic [4:0]  Rd_out,
    output logic [63:0] alu_result_out,
    output logic [63:0] dm_read_data_mem,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Last REQ cycle index before the access is abandoned.
    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    state_t      state;
    state_t      state_next;

    logic [63:0] lat_addr;
    logic [63:0] lat_wdata;
    logic [1:0]  lat_size;
    logic        lat_we;
    logic [4:0]  lat_rd;
    logic        lat_memtoreg;
    logic        lat_regwrite;
    logic        lat_brtaken;
    logic [63:0] rdata_cap;
    logic [7:0]  wait_cnt;
    logic        fault_flag;

    logic        mem_op;
    logic        misaligned;
    logic        timeout_hit;

    // Keeps the low 1/2/4/8 bytes selected by a transfer size.
    function automatic logic [63:0] size_mask(input logic [1:0] size);
        logic [63:0] m;
        case (size)
            2'd0:    m = 64'h0000_0000_0000_00FF;
            2'd1:    m = 64'h0000_0000_0000_FFFF;
            2'd2:    m = 64'h0000_0000_FFFF_FFFF;
            default: m = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return m;
    endfunction

    assign mem_op      = MemRead_mem | MemWrite_mem;
    assign timeout_hit = (wait_cnt == LAST_WAIT);

    // Alignment: the low 'size' address bits must be zero.
    always_comb begin
        misaligned = 1'b0;
        case (xfer_size_mem)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = alu_result_mem[0];
            2'd2:    misaligned = |alu_result_mem[1:0];
            default: misaligned = |alu_result_mem[2:0];
        endcase
    end

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next state and all stage outputs; everything is forced low during reset.
    always_comb begin
        state_next     = state;
        mem_stall      = 1'b0;
        mem_fault      = 1'b0;
        MemtoReg_out   = 1'b0;
        RegWrite_out   = 1'b0;
        BrTaken_out    = 1'b0;
        Rd_out         = 5'd0;
        alu_result_out = 64'd0;
        dm.dm_req      = 1'b0;
        if (!reset) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    MemtoReg_out   = MemtoReg_mem;
                    Rd_out         = Rd_mem;
                    alu_result_out = alu_result_mem;
                    if (!mem_op) begin
                        RegWrite_out = RegWrite_mem;
                        BrTaken_out  = BrTaken_mem;
                    end else if (misaligned) begin
                        // Dropped instruction: no access, no writeback, no stall.
                        mem_fault = 1'b1;
                    end else begin
                        mem_stall  = 1'b1;
                        state_next = REQ;
                    end
                end
                REQ: begin
                    dm.dm_req      = 1'b1;
                    mem_stall      = 1'b1;
                    MemtoReg_out   = lat_memtoreg;
                    Rd_out         = lat_rd;
                    alu_result_out = lat_addr;
                    if (dm.dm_ack || timeout_hit) state_next = DONE;
                end
                DONE: begin
                    MemtoReg_out   = lat_memtoreg;
                    RegWrite_out   = lat_regwrite & ~fault_flag;
                    BrTaken_out    = lat_brtaken;
                    Rd_out         = lat_rd;
                    alu_result_out = lat_addr;
                    mem_fault      = fault_flag;
                    state_next     = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Access latches, wait counter, fault flag and captured load data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_addr     <= 64'd0;
            lat_wdata    <= 64'd0;
            lat_size     <= 2'd0;
            lat_we       <= 1'b0;
            lat_rd       <= 5'd0;
            lat_memtoreg <= 1'b0;
            lat_regwrite <= 1'b0;
            lat_brtaken  <= 1'b0;
            rdata_cap    <= 64'd0;
            wait_cnt     <= 8'd0;
            fault_flag   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op && !misaligned) begin
                        lat_addr     <= alu_result_mem;
                        lat_wdata    <= wr_data_mem & size_mask(xfer_size_mem);
                        lat_size     <= xfer_size_mem;
                        lat_we       <= MemWrite_mem;
                        lat_rd       <= Rd_mem;
                        lat_memtoreg <= MemtoReg_mem;
                        lat_regwrite <= RegWrite_mem;
                        lat_brtaken  <= BrTaken_mem;
                        wait_cnt     <= 8'd0;
                        fault_flag   <= 1'b0;
                    end
                end
                REQ: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    if (dm.dm_ack) begin
                        if (!lat_we) rdata_cap <= dm.dm_rdata & size_mask(lat_size);
                    end else if (timeout_hit) begin
                        fault_flag <= 1'b1;
                    end
                end
                DONE: begin
                    wait_cnt   <= 8'd0;
                    fault_flag <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign dm.dm_we         = lat_we;
    assign dm.dm_size       = lat_size;
    assign dm.dm_addr       = lat_addr;
    assign dm.dm_wdata      = lat_wdata;
    assign dm_read_data_mem = rdata_cap;
    assign state_dbg        = state;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage controller of the pipelined CPU: drives a variable-latency data memory over a req/ack handshake, stalls the front of the pipeline while an access is outstanding, and presents the stage's results to the MEM/WB pipeline register. While a stall is in progress it injects a bubble, because MEM/WB has no enable. It sits between the EX/MEM register outputs and the MEM/WB register inputs.

## Interface
- MAX_WAIT, 15: cycles in REQ without dm_ack before the access is aborted; legal range 1-255.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- MemRead_mem, MemWrite_mem  in  1  load / store in MEM stage.
- MemtoReg_mem, RegWrite_mem, BrTaken_mem  in  1  control from EX/MEM.
- xfer_size_mem  in  2  access size: 0 byte, 1 half, 2 word, 3 dword.
- Rd_mem  in  5  destination register.
- alu_result_mem  in  64  ALU result; it is the address for memory ops.
- wr_data_mem  in  64  store data, right-aligned.
- dm_req  out  1  memory request, held until ack.
- dm_we  out  1  1 = write.
- dm_size  out  2  latched xfer_size.
- dm_addr  out  64  latched address.
- dm_wdata  out  64  latched store data, bits above size zeroed.
- dm_ack  in  1  one-cycle completion pulse.
- dm_rdata  in  64  read data, right-aligned; valid with dm_ack.
- mem_stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM.
- mem_fault  out  1  one-cycle pulse: misaligned access or timeout.
- MemtoReg_out, RegWrite_out, BrTaken_out  out  1  to MEM/WB.
- Rd_out  out  5  to MEM/WB.
- alu_result_out, dm_read_data_mem  out  64  to MEM/WB.

## Operation
- **States:** IDLE, REQ, DONE. Reset (reset=0) forces IDLE asynchronously.
- **Reset values:**
  - all outputs 0;
  - captured read data 0;
  - wait counter 0;
  - dm_req deasserts as soon as reset is low, including mid-access.
- **Misalignment:** a mem op is misaligned when address bits [size-1:0] are not all zero (e.g. dword needs addr[2:0]=0).
- **IDLE, no mem op:**
  - control, Rd and alu_result pass through combinationally;
  - mem_stall=0;
  - dm_read_data_mem holds its last captured value.
- **IDLE, aligned mem op:**
  - latch addr, size, we, wdata, Rd and control;
  - mem_stall=1;
  - RegWrite_out=0, BrTaken_out=0 (bubble);
  - next state REQ.
- **IDLE, misaligned mem op:**
  - no request is issued;
  - mem_fault=1 this cycle, mem_stall=0;
  - RegWrite_out=0, BrTaken_out=0; the instruction is dropped;
  - stay in IDLE.
- **REQ:**
  - dm_req=1, with dm_* driven from the latches;
  - mem_stall=1, bubble outputs;
  - counter increments each cycle.
  - On dm_ack: capture dm_rdata, zero-extended from size (loads only; stores leave the capture unchanged), then go to DONE.
  - If the counter reaches MAX_WAIT with no ack: abort. Drop dm_req, set the fault flag, go to DONE.
- **DONE:**
  - mem_stall=0;
  - outputs driven from the latches; dm_read_data_mem = captured data;
  - RegWrite_out = latched RegWrite, forced to 0 if the fault flag is set;
  - mem_fault=1 if the fault flag is set;
  - counter and flag clear; next state IDLE unconditionally (the upstream instruction advances this cycle).
- **Both MemRead and MemWrite set:** treated as a write.
- **dm_ack outside REQ:** ignored.
- **Stall contract:** EX/MEM inputs stay stable while mem_stall=1; this block does not re-sample them in REQ.

## Timing
- **Memory-op latency:** op arrives cycle N; REQ from N+1; ack in cycle N+1+k; DONE in N+2+k.
- **Stall:** asserted for cycles N through N+1+k (k+2 cycles); deasserted in DONE.
- **Minimum access** (ack in the first REQ cycle): 3 cycles per load/store, 2 of them stalled.
- **Non-memory op:** 0 added latency, never stalls.
- **Timeout:** DONE with mem_fault at cycle N+1+MAX_WAIT.
- **Back-to-back mem ops:** the second op is seen in the IDLE cycle after DONE. No overlap, no pipelined requests.

## Test plan
- **Reset:** reset low during REQ with dm_req=1 -> dm_req, mem_stall and all outputs drop to 0 immediately. After reset is released, an ALU op with RegWrite=1 and Rd=3 passes through the same cycle.
- **Load dword, ack after 2 REQ cycles:**
  - stimulus: addr 0x40, dm_rdata 0x1122334455667788;
  - mem_stall high for 3 cycles;
  - then DONE with RegWrite_out=1, MemtoReg_out=1 and dm_read_data_mem=0x1122334455667788.
- **Load byte:** addr 0x41, dm_rdata 0xFFFFFFFFFFFFFFAB, ack in the first REQ cycle -> dm_read_data_mem=0xAB; stall lasts 2 cycles.
- **Store half:** addr 0x42, wr_data 0xDEADBEEF -> dm_we=1, dm_size=1, dm_wdata=0xBEEF; dm_req held until ack.
- **Misaligned word:** addr 0x46 -> mem_fault pulse for 1 cycle, no dm_req, RegWrite_out=0, no stall.
- **Timeout:** MAX_WAIT=4, no ack -> dm_req high for 4 cycles, then DONE with mem_fault=1 and RegWrite_out=0. A load issued next completes normally.
